i2c_bus_frontend: RTL and testbench
===================================

// Module: i2c_bus_frontend
// PURPOSE
//   Upstream line conditioner and bit framer for the I2C peripheral. Samples raw
//   SCL/SDA pad inputs on the system clock, synchronises and glitch-filters them,
//   and detects SCL edges and START/STOP conditions. Frames bits into bytes and
//   hands them to the peripheral protocol engine, which owns addressing and SDA drive.
// PARAMETERS
//   FILTER_LEN  3  consecutive clk cycles a synced line must disagree with its filtered value before the filtered value flips (>=1)
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   scl_in      in   1  raw SCL pad input (asynchronous)
//   sda_in      in   1  raw SDA pad input (asynchronous)
//   scl_f       out  1  filtered SCL
//   sda_f       out  1  filtered SDA
//   scl_rise    out  1  1-cycle pulse, scl_f 0->1
//   scl_fall    out  1  1-cycle pulse, scl_f 1->0
//   start_det   out  1  1-cycle pulse, START or repeated START
//   stop_det    out  1  1-cycle pulse, STOP
//   bus_busy    out  1  high from START until STOP
//   bit_valid   out  1  1-cycle pulse, data/ack bit sampled
//   bit_data    out  1  sampled bit, valid with bit_valid
//   byte_valid  out  1  1-cycle pulse, 8 data bits assembled
//   byte_data   out  8  assembled byte, MSB first; holds until next byte_valid
//   ack_slot    out  1  high while bit_cnt==8 and bus_busy (9th clock window)
//   ack_valid   out  1  1-cycle pulse, 9th (ACK) bit sampled
//   ack_bit     out  1  sampled ACK bit (0=ACK), holds until next ack_valid
// BEHAVIOUR
//   Reset (async, rst_n=0): sync FFs, scl_f, sda_f = 1; filter counters, bit_cnt,
//     byte_data, ack_bit = 0; all pulses, bus_busy, ack_slot = 0.
//   Sync: two FFs per line. Filter: per-line counter. Clears on any cycle where
//     synced==filtered and increments on mismatch. On the FILTER_LEN-th consecutive
//     mismatch edge, filtered<=synced and counter clears.
//   Latency: clean pin step to filtered change = FILTER_LEN+2 clk edges (5 at default).
//     Pulses narrower than FILTER_LEN cycles at the sync output are removed.
//   Edges: x_f_d = x_f delayed 1 cycle. scl_rise = scl_f&~scl_f_d. scl_fall = ~scl_f&scl_f_d.
//   START: sda_f falling edge while scl_f and scl_f_d both 1.
//     Effect: start_det pulse, bus_busy<=1, bit_cnt<=0, partial shift register discarded.
//   STOP: sda_f rising edge while scl_f and scl_f_d both 1.
//     Effect: stop_det pulse, bus_busy<=0, bit_cnt<=0, partial discarded.
//   Simultaneous scl_f and sda_f change in one cycle: no START/STOP; SCL edge reported normally.
//   Framing: counts only while bus_busy=1 and start_det=0; scl edges otherwise ignored
//     for framing, but scl_rise/scl_fall still pulse.
//   On scl_rise: bit_valid pulses the same cycle with bit_data=sda_f.
//     bit_cnt 0..7: shift sda_f in MSB first, bit_cnt++.
//     bit_cnt==7: also byte_valid pulse; byte_data = {shift[6:0],sda_f} in the same cycle.
//     bit_cnt==8: ack_valid pulse, ack_bit<=sda_f, bit_cnt<=0.
//   ack_slot is high from the cycle after the 8th scl_rise through the cycle of the 9th scl_rise.
//   Repeated START or STOP mid-byte or mid-ACK: no byte_valid/ack_valid for the partial frame.
//   rst_n assert mid-transfer: everything returns to reset values immediately.
//   After deassert, a line that is low appears on x_f after FILTER_LEN+2 edges; no START is flagged.
// TESTING
//   1 Reset: rst_n=0 with both lines high -> scl_f=sda_f=1, bus_busy=0, byte_data=0, no pulses.
//   2 Filter: SCL high, SDA low glitch for 2 clk -> sda_f stays 1, no start_det.
//     SCL held low from edge N -> scl_f falls at edge N+5, single scl_fall pulse.
//   3 START, byte 0xA5, SDA low on 9th clock -> start_det, 8 bit_valid, byte_valid with
//     byte_data=0xA5, ack_slot high, ack_valid with ack_bit=0.
//   4 START, 3 bits 101, repeated START, byte 0x3C -> no byte_valid for partial,
//     second start_det, byte_valid with 0x3C.
//   5 STOP after byte -> stop_det, bus_busy=0; 4 further SCL pulses give scl_rise but no bit_valid.
//   6 rst_n low after 5 bits -> immediate reset values. Then a new START and 0xFF -> byte_valid 0xFF.

Source files
------------

// File: rtl/i2c_bus_frontend.sv
// I2C line conditioner: pad sync, glitch filter, SCL edge and START/STOP
// detection, and bit/byte/ACK framing for the protocol engine.
module i2c_bus_frontend #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_slot,
    output logic       ack_valid,
    output logic       ack_bit
);

    localparam int CW    = $clog2(FILTER_LEN + 1);
    localparam int ARM_N = FILTER_LEN + 3;
    localparam int AW    = $clog2(ARM_N + 1);

    logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic          scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic          scl_dly_q, sda_dly_q;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic          bus_busy_q, bus_busy_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          ack_bit_q, ack_bit_d;
    logic          armed, sda_rise, sda_fall;

    // Lines that are already low at reset release would otherwise look
    // like a START once they work through the filter.
    assign armed = (arm_cnt_q == AW'(ARM_N));

    assign scl_f     = scl_filt_q;
    assign sda_f     = sda_filt_q;
    assign scl_rise  = scl_filt_q & ~scl_dly_q;
    assign scl_fall  = ~scl_filt_q & scl_dly_q;
    assign sda_rise  = sda_filt_q & ~sda_dly_q;
    assign sda_fall  = ~sda_filt_q & sda_dly_q;
    assign start_det = armed & sda_fall & scl_filt_q & scl_dly_q;
    assign stop_det  = armed & sda_rise & scl_filt_q & scl_dly_q;
    assign bus_busy  = bus_busy_q;

    assign bit_valid  = scl_rise & bus_busy_q & ~start_det;
    assign bit_data   = sda_filt_q;
    assign byte_valid = bit_valid & (bit_cnt_q == 4'd7);
    assign ack_valid  = bit_valid & (bit_cnt_q == 4'd8);
    assign ack_slot   = bus_busy_q & (bit_cnt_q == 4'd8);
    assign byte_data  = byte_valid ? {shift_q, sda_filt_q} : byte_data_q;
    assign ack_bit    = ack_valid ? sda_filt_q : ack_bit_q;

    always_comb begin
        scl_s1_d    = scl_in;
        scl_s2_d    = scl_s1_q;
        sda_s1_d    = sda_in;
        sda_s2_d    = sda_s1_q;
        scl_cnt_d   = '0;
        sda_cnt_d   = '0;
        scl_filt_d  = scl_filt_q;
        sda_filt_d  = sda_filt_q;
        arm_cnt_d   = armed ? arm_cnt_q : arm_cnt_q + AW'(1);
        bus_busy_d  = bus_busy_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_data_d = byte_data_q;
        ack_bit_d   = ack_bit_q;

        if (scl_s2_q != scl_filt_q) begin
            if (scl_cnt_q == CW'(FILTER_LEN - 1))
                scl_filt_d = scl_s2_q;
            else
                scl_cnt_d = scl_cnt_q + CW'(1);
        end
        if (sda_s2_q != sda_filt_q) begin
            if (sda_cnt_q == CW'(FILTER_LEN - 1))
                sda_filt_d = sda_s2_q;
            else
                sda_cnt_d = sda_cnt_q + CW'(1);
        end

        if (start_det) begin
            bus_busy_d = 1'b1;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else if (stop_det) begin
            bus_busy_d = 1'b0;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else if (bit_valid) begin
            if (bit_cnt_q == 4'd8) begin
                bit_cnt_d = '0;
                ack_bit_d = sda_filt_q;
            end else begin
                shift_d   = {shift_q[5:0], sda_filt_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (byte_valid)
                byte_data_d = {shift_q, sda_filt_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            scl_cnt_q   <= '0;
            sda_cnt_q   <= '0;
            scl_filt_q  <= 1'b1;
            sda_filt_q  <= 1'b1;
            scl_dly_q   <= 1'b1;
            sda_dly_q   <= 1'b1;
            arm_cnt_q   <= '0;
            bus_busy_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_data_q <= '0;
            ack_bit_q   <= 1'b0;
        end else begin
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
            scl_cnt_q   <= scl_cnt_d;
            sda_cnt_q   <= sda_cnt_d;
            scl_filt_q  <= scl_filt_d;
            sda_filt_q  <= sda_filt_d;
            scl_dly_q   <= scl_filt_q;
            sda_dly_q   <= sda_filt_q;
            arm_cnt_q   <= arm_cnt_d;
            bus_busy_q  <= bus_busy_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_data_q <= byte_data_d;
            ack_bit_q   <= ack_bit_d;
        end
    end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: filter timing, START/STOP,
// byte and ACK framing, repeated START, STOP, and mid-transfer reset.
module tb_i2c_bus_frontend;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_f, sda_f, scl_rise, scl_fall;
    logic       start_det, stop_det, bus_busy;
    logic       bit_valid, bit_data, byte_valid;
    logic [7:0] byte_data;
    logic       ack_slot, ack_valid, ack_bit;

    int n_checks = 0;
    int n_fail = 0;

    int n_start = 0, n_stop = 0, n_bit = 0, n_byte = 0;
    int n_ack = 0, n_rise = 0, n_fall = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_ack = 1'b0;

    i2c_bus_frontend #(.FILTER_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f),
        .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det),
        .bus_busy(bus_busy),
        .bit_valid(bit_valid), .bit_data(bit_data),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .ack_slot(ack_slot), .ack_valid(ack_valid),
        .ack_bit(ack_bit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (bit_valid) n_bit++;
        if (scl_rise) n_rise++;
        if (scl_fall) n_fall++;
        if (byte_valid) begin
            n_byte++;
            last_byte = byte_data;
        end
        if (ack_valid) begin
            n_ack++;
            last_ack = ack_bit;
        end
    end

    task automatic drive(input logic scl, input logic sda);
        scl_in = scl;
        sda_in = sda;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic i2c_rstart();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic i2c_stop();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b0, b);
        drive(1'b1, b);
        drive(1'b0, b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({scl_f, sda_f, bus_busy, ack_slot} !== 4'b1100) begin
            $display("FAIL reset_lines: got %b want 1100",
                     {scl_f, sda_f, bus_busy, ack_slot});
            n_fail++;
        end
        n_checks++;
        if (byte_data !== 8'h00 || ack_bit !== 1'b0) begin
            $display("FAIL reset_data: got %h/%b want 00/0",
                     byte_data, ack_bit);
            n_fail++;
        end
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (n_start + n_stop + n_bit + n_rise + n_fall + n_byte != 0) begin
            $display("FAIL reset_pulses: got %0d pulses want 0",
                     n_start + n_stop + n_bit + n_rise + n_fall + n_byte);
            n_fail++;
        end
    endtask

    task automatic test_filter();
        int s0, f0;
        logic sda_dip;
        s0 = n_start;
        sda_dip = 1'b0;
        @(posedge clk);
        #1 sda_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 sda_in = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (sda_f !== 1'b1) sda_dip = 1'b1;
        end
        n_checks++;
        if (sda_dip !== 1'b0 || n_start != s0) begin
            $display("FAIL glitch: sda_dip %b starts %0d want 0 0",
                     sda_dip, n_start - s0);
            n_fail++;
        end
        f0 = n_fall;
        @(posedge clk);
        #1 scl_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (scl_f !== (k < 5)) begin
                $display("FAIL scl_latency_e%0d: got %b want %b",
                         k, scl_f, (k < 5));
                n_fail++;
            end
        end
        n_checks++;
        if (scl_fall !== 1'b1) begin
            $display("FAIL scl_fall_pulse: got %b want 1", scl_fall);
            n_fail++;
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_fall - f0 != 1) begin
            $display("FAIL scl_fall_count: got %0d want 1", n_fall - f0);
            n_fail++;
        end
        drive(1'b1, 1'b1);
    endtask

    task automatic test_start_byte();
        int s0, b0, y0, a0;
        s0 = n_start;
        b0 = n_bit;
        y0 = n_byte;
        a0 = n_ack;
        i2c_start();
        n_checks++;
        if (n_start - s0 != 1 || bus_busy !== 1'b1) begin
            $display("FAIL start: got starts %0d busy %b want 1 1",
                     n_start - s0, bus_busy);
            n_fail++;
        end
        send_byte(8'hA5);
        n_checks++;
        if (n_bit - b0 != 8 || n_byte - y0 != 1 || last_byte !== 8'hA5) begin
            $display("FAIL byte_a5: got bits %0d bytes %0d data %h want 8 1 a5",
                     n_bit - b0, n_byte - y0, last_byte);
            n_fail++;
        end
        n_checks++;
        if (ack_slot !== 1'b1) begin
            $display("FAIL ack_slot_hi: got %b want 1", ack_slot);
            n_fail++;
        end
        send_bit(1'b0);
        n_checks++;
        if (n_ack - a0 != 1 || last_ack !== 1'b0 || ack_bit !== 1'b0) begin
            $display("FAIL ack0: got acks %0d bit %b/%b want 1 0/0",
                     n_ack - a0, last_ack, ack_bit);
            n_fail++;
        end
        n_checks++;
        if (ack_slot !== 1'b0 || n_bit - b0 != 9) begin
            $display("FAIL ack_slot_lo: got slot %b bits %0d want 0 9",
                     ack_slot, n_bit - b0);
            n_fail++;
        end
    endtask

    task automatic test_repeated_start();
        int s0, y0, a0;
        s0 = n_start;
        y0 = n_byte;
        a0 = n_ack;
        i2c_rstart();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_rstart();
        n_checks++;
        if (n_start - s0 != 2 || n_byte != y0) begin
            $display("FAIL partial: got starts %0d bytes %0d want 2 0",
                     n_start - s0, n_byte - y0);
            n_fail++;
        end
        n_checks++;
        if (byte_data !== 8'hA5) begin
            $display("FAIL byte_hold: got %h want a5", byte_data);
            n_fail++;
        end
        send_byte(8'h3C);
        n_checks++;
        if (n_byte - y0 != 1 || last_byte !== 8'h3C || byte_data !== 8'h3C) begin
            $display("FAIL byte_3c: got bytes %0d data %h/%h want 1 3c/3c",
                     n_byte - y0, last_byte, byte_data);
            n_fail++;
        end
        send_bit(1'b1);
        n_checks++;
        if (n_ack - a0 != 1 || ack_bit !== 1'b1) begin
            $display("FAIL nack: got acks %0d bit %b want 1 1",
                     n_ack - a0, ack_bit);
            n_fail++;
        end
    endtask

    task automatic test_stop();
        int p0, b0, r0, s0;
        p0 = n_stop;
        i2c_stop();
        n_checks++;
        if (n_stop - p0 != 1 || bus_busy !== 1'b0) begin
            $display("FAIL stop: got stops %0d busy %b want 1 0",
                     n_stop - p0, bus_busy);
            n_fail++;
        end
        b0 = n_bit;
        r0 = n_rise;
        s0 = n_start;
        repeat (4) begin
            drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
        end
        n_checks++;
        if (n_rise - r0 != 4 || n_bit != b0 || n_start != s0) begin
            $display("FAIL idle_scl: got rises %0d bits %0d starts %0d want 4 0 0",
                     n_rise - r0, n_bit - b0, n_start - s0);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int y0, s0;
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({scl_f, sda_f, bus_busy, ack_slot, ack_bit} !== 5'b11000
            || byte_data !== 8'h00) begin
            $display("FAIL mid_reset: got %b/%h want 11000/00",
                     {scl_f, sda_f, bus_busy, ack_slot, ack_bit}, byte_data);
            n_fail++;
        end
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        y0 = n_byte;
        s0 = n_start;
        i2c_start();
        send_byte(8'hFF);
        send_bit(1'b0);
        n_checks++;
        if (n_start - s0 != 1 || n_byte - y0 != 1 || last_byte !== 8'hFF) begin
            $display("FAIL after_reset: got starts %0d bytes %0d data %h want 1 1 ff",
                     n_start - s0, n_byte - y0, last_byte);
            n_fail++;
        end
        i2c_stop();
    endtask

    task automatic test_low_at_release();
        int s0;
        rst_n = 1'b0;
        scl_in = 1'b1;
        sda_in = 1'b0;
        repeat (3) @(posedge clk);
        s0 = n_start;
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (sda_f !== 1'b0 || n_start != s0 || bus_busy !== 1'b0) begin
            $display("FAIL low_release: got sda_f %b starts %0d busy %b want 0 0 0",
                     sda_f, n_start - s0, bus_busy);
            n_fail++;
        end
        drive(1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_filter();
        test_start_byte();
        test_repeated_start();
        test_stop();
        test_reset_mid();
        test_low_at_release();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
